axil_master: RTL and testbench



---
 rtl/axil_master.sv | 172 +++++++++++++++++
 tb/tb_axil_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding AXI4-Lite initiator behind a cmd/rsp handshake.
// Optional AXIL_MASTER_ALIGN_CHECK_EN: misaligned commands answer SLVERR without touching AXI.
module axil_master #(
  parameter int          ADDR_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_B,
    S_READ_A,
    S_WAIT_R,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              rsp_write_q, rsp_write_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              aw_hs, w_hs, ar_hs;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= S_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    aw_hs       = m_axi_awvalid && m_axi_awready;
    w_hs        = m_axi_wvalid && m_axi_wready;
    ar_hs       = m_axi_arvalid && m_axi_arready;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          rsp_write_d = cmd_write;
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
          if (cmd_addr[1:0] != 2'b00) begin
            rsp_resp_d  = 2'b10;
            rsp_rdata_d = '0;
            state_d     = S_RESP;
          end else
`endif
          if (cmd_write) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WRITE;
          end else begin
            state_d = S_READ_A;
          end
        end
      end
      S_WRITE: begin
        // AW and W retire independently; leave once both are done, same cycle included.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (m_axi_bvalid) begin
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_READ_A: begin
        if (ar_hs) state_d = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (m_axi_rvalid) begin
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
          rsp_write_d = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = PROT;
  assign m_axi_awvalid = (state_q == S_WRITE) && !aw_done_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = (state_q == S_WRITE) && !w_done_q;
  assign m_axi_bready  = (state_q == S_WAIT_B);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = PROT;
  assign m_axi_arvalid = (state_q == S_READ_A);
  assign m_axi_rready  = (state_q == S_WAIT_R);

endmodule

// File: tb/tb_axil_master.sv
// tb/tb_axil_master.sv - randomized bench for axil_master against a memory-level reference model.
// Honours AXIL_MASTER_ALIGN_CHECK_EN to match the design build.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_write;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  axil_master #(.ADDR_W(32), .PROT(3'b000)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave environment: 64-word memory, region 0xF0-0xFF answers SLVERR, 0xE0-0xEF DECERR.
  logic [31:0] smem [64];
  logic [31:0] rmem [64];
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int aw_seen, w_seen, ar_seen, bw, rw;
  bit aw_have, w_have, ar_have, b_hs, r_hs;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, prot_err = 0;
  int aw_vcyc, w_vcyc, ar_vcyc;
  int exp_wr = 0, exp_rd = 0;
  bit p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  int sidx;

  function automatic logic [1:0] region_resp(input logic [31:0] a);
    if (a[7:4] == 4'hF) return 2'b10;
    if (a[7:4] == 4'hE) return 2'b11;
    return 2'b00;
  endfunction

  task automatic slave_clear();
    aw_have = 0; w_have = 0; ar_have = 0; b_hs = 0; r_hs = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; bw = 0; rw = 0;
    p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_rvalid = 0;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (m_axi_awvalid) aw_vcyc++;
        if (m_axi_wvalid)  w_vcyc++;
        if (m_axi_arvalid) ar_vcyc++;
        if (p_awv && !p_awhs && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) prot_err++;
        if (p_wv && !p_whs && (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb)) prot_err++;
        if (p_arv && !p_arhs && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) prot_err++;
        if ((m_axi_bready || m_axi_rready) && (cmd_ready || rsp_valid)) prot_err++;
        p_awv = m_axi_awvalid; p_awhs = m_axi_awvalid && m_axi_awready; p_awaddr = m_axi_awaddr;
        p_wv = m_axi_wvalid; p_whs = m_axi_wvalid && m_axi_wready;
        p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
        p_arv = m_axi_arvalid; p_arhs = m_axi_arvalid && m_axi_arready; p_araddr = m_axi_araddr;
        if (p_awhs) begin aw_have = 1; s_awaddr = m_axi_awaddr; aw_seen = 0; n_aw++; end
        if (p_whs) begin w_have = 1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; w_seen = 0; n_w++; end
        if (p_arhs) begin ar_have = 1; s_araddr = m_axi_araddr; ar_seen = 0; n_ar++; end
        if (m_axi_bvalid && m_axi_bready) begin b_hs = 1; n_b++; end
        if (m_axi_rvalid && m_axi_rready) begin r_hs = 1; n_r++; end
      end
      @(negedge clk);
      if (!rst_n) begin
        slave_clear();
      end else begin
        if (b_hs) begin m_axi_bvalid = 0; b_hs = 0; end
        if (r_hs) begin m_axi_rvalid = 0; r_hs = 0; end
        if (aw_have && w_have && !m_axi_bvalid) begin
          if (bw >= b_dly) begin
            sidx = int'(s_awaddr[7:2]);
            m_axi_bresp = region_resp(s_awaddr);
            if (m_axi_bresp == 2'b00)
              for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) smem[sidx][8*b +: 8] = s_wdata[8*b +: 8];
            m_axi_bvalid = 1; aw_have = 0; w_have = 0; bw = 0;
          end else bw++;
        end
        if (ar_have && !m_axi_rvalid) begin
          if (rw >= r_dly) begin
            sidx = int'(s_araddr[7:2]);
            m_axi_rresp = region_resp(s_araddr);
            m_axi_rdata = (m_axi_rresp == 2'b00) ? smem[sidx] : 32'hBAD0_0000;
            m_axi_rvalid = 1; ar_have = 0; rw = 0;
          end else rw++;
        end
        if (m_axi_awvalid && !aw_have) aw_seen++;
        if (m_axi_wvalid && !w_have)   w_seen++;
        if (m_axi_arvalid && !ar_have) ar_seen++;
        m_axi_awready = !aw_have && (aw_dly == 0 || aw_seen > aw_dly);
        m_axi_wready  = !w_have  && (w_dly == 0  || w_seen > w_dly);
        m_axi_arready = !ar_have && (ar_dly == 0 || ar_seen > ar_dly);
      end
    end
  end

  // Reference: what the requester should see, derived from the memory contents and address rules.
  function automatic void model(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] erd,
                                output logic [1:0] err, output bit axi);
    int idx;
    idx = int'(a[7:2]);
    axi = 1;
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) begin
      erd = 0; err = 2'b10; axi = 0;
      return;
    end
`endif
    err = region_resp(a);
    if (wr) begin
      erd = 0;
      if (err == 2'b00)
        for (int b = 0; b < 4; b++)
          if (s[b]) rmem[idx][8*b +: 8] = d[8*b +: 8];
    end else begin
      erd = (err == 2'b00) ? rmem[idx] : 32'hBAD0_0000;
    end
  endfunction

  task automatic run_cmd(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold, output logic [31:0] rd,
                         output logic [1:0] rr, output logic rwr, output int lat);
    bit acc;
    int n, bad;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    aw_vcyc = 0; w_vcyc = 0; ar_vcyc = 0;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      @(posedge clk);
      if (cmd_ready) acc = 1;
      n++;
    end
    if (!acc) check({tag, "_accept"}, 32'(acc), 32'd1);
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
    rd = rsp_rdata; rr = rsp_resp; rwr = rsp_write;
    bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_resp !== rr || rsp_rdata !== rd || rsp_write !== rwr || cmd_ready) bad++;
    end
    check({tag, "_hold"}, 32'(bad), 32'd0);
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    check({tag, "_idle_after"}, 32'({cmd_ready, rsp_valid}), 32'b10);
  endtask

  task automatic do_txn(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, output int lat);
    logic [31:0] erd, rd;
    logic [1:0]  err, rr;
    logic        rwr;
    bit          axi;
    model(wr, a, d, s, erd, err, axi);
    if (axi) begin
      if (wr) exp_wr++; else exp_rd++;
    end
    run_cmd(tag, wr, a, d, s, hold, rd, rr, rwr, lat);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_resp"}, 32'(rr), 32'(err));
    check({tag, "_write"}, 32'(rwr), 32'(wr));
    if (axi && wr) begin
      check({tag, "_awaddr"}, s_awaddr, a);
      check({tag, "_wdata"}, s_wdata, d);
      check({tag, "_wstrb"}, 32'(s_wstrb), 32'(s));
    end
    if (axi && !wr) check({tag, "_araddr"}, s_araddr, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int lat, nb, nar;
    logic [31:0] rnd, d;
    int idx;
    bit wr;
    for (int i = 0; i < 64; i++) begin
      rmem[i] = $urandom;
      smem[i] = rmem[i];
    end
    rmem[2] = 32'h0000_BABA;
    smem[2] = 32'h0000_BABA;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                           m_axi_rready, rsp_valid, cmd_ready}), 32'b0000001);
    check("rst_data", m_axi_awaddr | m_axi_araddr | m_axi_wdata | 32'(m_axi_wstrb), 32'd0);
    check("rst_rsp", rsp_rdata | 32'({rsp_resp, rsp_write}), 32'd0);
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("rst_release", 32'({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_arvalid}), 32'b1000);

    do_txn("rd08", 0, 32'h08, 32'h0, 4'h0, 0, lat);
    check("rd08_lat", 32'(lat), 32'd3);
    check("rd08_arv_cycles", 32'(ar_vcyc), 32'd1);

    aw_dly = 0; w_dly = 2;
    do_txn("wr04", 1, 32'h04, 32'h0000_12AA, 4'hF, 0, lat);
    check("wr04_awv_cycles", 32'(aw_vcyc), 32'd1);
    check("wr04_wv_cycles", 32'(w_vcyc), 32'd3);

    aw_dly = 2; w_dly = 0;
    nb = n_b;
    do_txn("wr_wfirst", 1, 32'h10, 32'h9, 4'hF, 0, lat);
    check("wr_wfirst_b_count", 32'(n_b - nb), 32'd1);
    check("wr_wfirst_awv_cycles", 32'(aw_vcyc), 32'd3);
    aw_dly = 0; w_dly = 0;
    nb = n_b;
    do_txn("wr_same", 1, 32'h14, 32'hA, 4'hF, 0, lat);
    check("wr_same_b_count", 32'(n_b - nb), 32'd1);
    check("wr_same_lat", 32'(lat), 32'd3);

    b_dly = 1;
    do_txn("wr_slverr", 1, 32'hF0, 32'h55, 4'hF, 5, lat);
    b_dly = 0;

    aw_dly = 8; w_dly = 8;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0C; cmd_wdata = 32'h1234; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    check("rst_mid_valids", 32'({m_axi_awvalid, m_axi_wvalid}), 32'b11);
    @(posedge clk);
    #2 rst_n = 0;
    #1 check("rst_mid_async", 32'({m_axi_awvalid, m_axi_wvalid, rsp_valid, cmd_ready}), 32'b0001);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    aw_dly = 0; w_dly = 0;
    do_txn("rd_after_rst", 0, 32'h08, 32'h0, 4'h0, 0, lat);
    check("rd_after_rst_lat", 32'(lat), 32'd3);

    nar = n_ar;
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
    do_txn("rd06_align", 0, 32'h06, 32'h0, 4'h0, 0, lat);
    check("rd06_lat", 32'(lat), 32'd1);
    check("rd06_no_ar", 32'(n_ar - nar + ar_vcyc), 32'd0);
`else
    do_txn("rd06_fwd", 0, 32'h06, 32'h0, 4'h0, 0, lat);
    check("rd06_ar_count", 32'(n_ar - nar), 32'd1);
`endif

    for (int i = 0; i < 40; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 2); r_dly = $urandom_range(0, 2);
      rnd = $urandom;
      idx = $urandom_range(0, 63);
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      do_txn("rnd", wr, {rnd[31:8], 6'(idx), 2'b00}, d, 4'($urandom_range(0, 15)),
             $urandom_range(0, 2), lat);
    end

    check("total_aw", 32'(n_aw), 32'(exp_wr));
    check("total_w", 32'(n_w), 32'(exp_wr));
    check("total_b", 32'(n_b), 32'(exp_wr));
    check("total_ar", 32'(n_ar), 32'(exp_rd));
    check("total_r", 32'(n_r), 32'(exp_rd));
    check("protocol", 32'(prot_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
